// File: rtl/regfile_pkg.sv
// -----------------------------------------------------------------------------
// regfile_pkg
// Shared definitions for the multi-port integer register file and its
// scoreboard: default geometry and the register address/word types used at
// that default geometry.
// -----------------------------------------------------------------------------
package regfile_pkg;

    localparam int unsigned DefWidth = 32;
    localparam int unsigned DefDepth = 32;
    localparam int unsigned DefAw    = $clog2(DefDepth);

    typedef logic [DefAw-1:0]    reg_addr_t;
    typedef logic [DefWidth-1:0] reg_word_t;

endpackage : regfile_pkg

// File: rtl/regfile_scoreboard.sv
// -----------------------------------------------------------------------------
// regfile_scoreboard
// One busy bit per architectural register, tracking destinations that have
// been reserved at issue but not yet retired by writeback.
//
// Ports:
//   clk       rising-edge clock
//   rst_n     synchronous active-low reset, clears every busy bit
//   flush     clears every busy bit (pipeline squash), beats rsv_en
//   rsv_en    mark rsv_addr busy
//   rsv_addr  register to reserve
//   wr_en     per-write-port enable
//   wr_addr   per-write-port address, packed NUM_WR x AW
//   wr_clr    per-write-port: this write retires the reservation
//   rd_addr   per-read-port address, packed NUM_RD x AW
//   rd_busy   per-read-port busy, with same-cycle retiring writes masked
// -----------------------------------------------------------------------------
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int unsigned DEPTH    = DefDepth,
    parameter int unsigned AW       = $clog2(DEPTH),
    parameter int unsigned NUM_RD   = 2,
    parameter int unsigned NUM_WR   = 2,
    parameter bit          ZERO_REG = 1'b1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush,
    input  logic                     rsv_en,
    input  logic [AW-1:0]            rsv_addr,
    input  logic [NUM_WR-1:0]        wr_en,
    input  logic [NUM_WR*AW-1:0]     wr_addr,
    input  logic [NUM_WR-1:0]        wr_clr,
    input  logic [NUM_RD*AW-1:0]     rd_addr,
    output logic [NUM_RD-1:0]        rd_busy
);

    logic [DEPTH-1:0] busy_q;
    logic [DEPTH-1:0] busy_d;

    // Priority, lowest to highest: retire clears, reservation set, flush.
    // A set beating a clear on the same register means the newer producer
    // supersedes the one that is just retiring.
    always_comb begin
        busy_d = busy_q;
        for (int i = 0; i < NUM_WR; i++) begin
            if (wr_en[i] && wr_clr[i]) begin
                busy_d[wr_addr[i*AW +: AW]] = 1'b0;
            end
        end
        if (rsv_en) begin
            busy_d[rsv_addr] = 1'b1;
        end
        if (flush) begin
            busy_d = '0;
        end
        // Register 0 is hardwired and can never have a pending producer.
        if (ZERO_REG) begin
            busy_d[0] = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    // Lookup is on the registered vector, so a same-cycle reservation only
    // shows up next cycle; a same-cycle retiring write is masked so the
    // bypassed data can be consumed immediately.
    for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
        logic [AW-1:0] ra;
        logic          clr_hit;

        assign ra = rd_addr[p*AW +: AW];

        always_comb begin
            clr_hit = 1'b0;
            for (int i = 0; i < NUM_WR; i++) begin
                if (wr_en[i] && wr_clr[i] && (wr_addr[i*AW +: AW] == ra)) begin
                    clr_hit = 1'b1;
                end
            end
        end

        assign rd_busy[p] = busy_q[ra] & ~clr_hit;
    end

endmodule : regfile_scoreboard

// File: rtl/regfile_sb.sv
// -----------------------------------------------------------------------------
// regfile_sb
// Multi-port integer register file with write-to-read bypass and a
// per-register scoreboard for RAW hazard detection in decode.
//
// Ports:
//   clk       rising-edge clock
//   rst_n     synchronous active-low reset: data and busy bits to 0
//   flush     clear all busy bits; writes in the same cycle still land
//   rd_addr   read address per port, packed NUM_RD x AW
//   rd_data   read data per port (bypassed), packed NUM_RD x WIDTH
//   rd_busy   per read port: a write to rd_addr is still pending
//   rsv_en    reserve a destination at issue
//   rsv_addr  register to mark busy
//   wr_en     write enable per port
//   wr_addr   write address per port, packed NUM_WR x AW
//   wr_data   write data per port, packed NUM_WR x WIDTH
//   wr_clr    per write port: also retire the reservation on wr_addr
// -----------------------------------------------------------------------------
module regfile_sb
    import regfile_pkg::*;
#(
    parameter int unsigned WIDTH    = DefWidth,
    parameter int unsigned DEPTH    = DefDepth,
    parameter int unsigned NUM_RD   = 2,
    parameter int unsigned NUM_WR   = 2,
    parameter bit          ZERO_REG = 1'b1,
    localparam int unsigned AW      = $clog2(DEPTH)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      flush,
    input  logic [NUM_RD*AW-1:0]      rd_addr,
    output logic [NUM_RD*WIDTH-1:0]   rd_data,
    output logic [NUM_RD-1:0]         rd_busy,
    input  logic                      rsv_en,
    input  logic [AW-1:0]             rsv_addr,
    input  logic [NUM_WR-1:0]         wr_en,
    input  logic [NUM_WR*AW-1:0]      wr_addr,
    input  logic [NUM_WR*WIDTH-1:0]   wr_data,
    input  logic [NUM_WR-1:0]         wr_clr
);

    // Flop array: the read ports are asynchronous, so this cannot map to RAM.
    logic [WIDTH-1:0] data_q [DEPTH];
    logic [WIDTH-1:0] data_d [DEPTH];

    // Ports are applied in ascending order so the highest-index write wins.
    always_comb begin
        data_d = data_q;
        for (int i = 0; i < NUM_WR; i++) begin
            if (wr_en[i] && !(ZERO_REG && (wr_addr[i*AW +: AW] == '0))) begin
                data_d[wr_addr[i*AW +: AW]] = wr_data[i*WIDTH +: WIDTH];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int r = 0; r < DEPTH; r++) begin
                data_q[r] <= '0;
            end
        end else begin
            data_q <= data_d;
        end
    end

    // Bypass mux uses the same ascending order as the write path, so a
    // bypassed value always matches what will be stored at the edge.
    for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
        logic [AW-1:0]    ra;
        logic [WIDTH-1:0] rdat;

        assign ra = rd_addr[p*AW +: AW];

        always_comb begin
            rdat = data_q[ra];
            for (int i = 0; i < NUM_WR; i++) begin
                if (wr_en[i] && (wr_addr[i*AW +: AW] == ra)) begin
                    rdat = wr_data[i*WIDTH +: WIDTH];
                end
            end
            if (ZERO_REG && (ra == '0)) begin
                rdat = '0;
            end
        end

        assign rd_data[p*WIDTH +: WIDTH] = rdat;
    end

    regfile_scoreboard #(
        .DEPTH    (DEPTH),
        .AW       (AW),
        .NUM_RD   (NUM_RD),
        .NUM_WR   (NUM_WR),
        .ZERO_REG (ZERO_REG)
    ) u_scoreboard (
        .clk      (clk),
        .rst_n    (rst_n),
        .flush    (flush),
        .rsv_en   (rsv_en),
        .rsv_addr (rsv_addr),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_clr   (wr_clr),
        .rd_addr  (rd_addr),
        .rd_busy  (rd_busy)
    );

endmodule : regfile_sb

// File: tb/tb_regfile_sb.sv
module tb_regfile_sb;

    localparam int unsigned W  = 32;
    localparam int unsigned AW = 5;
    localparam int unsigned NR = 2;
    localparam int unsigned NW = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rst_n;
    logic             flush;
    logic [NR*AW-1:0] rd_addr;
    logic [NR*W-1:0]  rd_data;
    logic [NR-1:0]    rd_busy;
    logic             rsv_en;
    logic [AW-1:0]    rsv_addr;
    logic [NW-1:0]    wr_en;
    logic [NW*AW-1:0] wr_addr;
    logic [NW*W-1:0]  wr_data;
    logic [NW-1:0]    wr_clr;

    int n_vec = 0;
    int n_err = 0;

    regfile_sb dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .flush    (flush),
        .rd_addr  (rd_addr),
        .rd_data  (rd_data),
        .rd_busy  (rd_busy),
        .rsv_en   (rsv_en),
        .rsv_addr (rsv_addr),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .wr_clr   (wr_clr)
    );

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, want %h", tag, act, exp);
        end
    endtask

    task automatic idle();
        flush    = 1'b0;
        rsv_en   = 1'b0;
        rsv_addr = '0;
        wr_en    = '0;
        wr_addr  = '0;
        wr_data  = '0;
        wr_clr   = '0;
    endtask

    task automatic set_rd(input int p, input logic [AW-1:0] a);
        rd_addr[p*AW +: AW] = a;
    endtask

    task automatic set_wr(input int p, input logic [AW-1:0] a, input logic [W-1:0] d,
                          input logic clr);
        wr_en[p]            = 1'b1;
        wr_addr[p*AW +: AW] = a;
        wr_data[p*W +: W]   = d;
        wr_clr[p]           = clr;
    endtask

    task automatic reserve(input logic [AW-1:0] a);
        rsv_en   = 1'b1;
        rsv_addr = a;
    endtask

    // Advance one edge; inputs change 1 time unit after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_rd(input string tag, input int p, input logic [W-1:0] exp);
        #1;
        check_val(tag, rd_data[p*W +: W], exp);
    endtask

    task automatic chk_busy(input string tag, input int p, input logic exp);
        #1;
        check_val(tag, {31'b0, rd_busy[p]}, {31'b0, exp});
    endtask

    initial begin
        rst_n   = 1'b0;
        rd_addr = '0;
        idle();
        step();
        step();
        rst_n = 1'b1;

        // Preload x1..x31 with nonzero data, two registers per cycle.
        for (int a = 1; a < 32; a += 2) begin
            idle();
            set_wr(0, 5'(a), 32'h1000_0000 + 32'(a), 1'b0);
            if (a + 1 < 32) set_wr(1, 5'(a + 1), 32'h1000_0000 + 32'(a + 1), 1'b0);
            step();
        end
        idle();
        reserve(5'd10);
        step();
        idle();
        set_rd(0, 5'd1);
        set_rd(1, 5'd10);
        chk_rd("preload x1", 0, 32'h1000_0001);
        chk_rd("preload x10", 1, 32'h1000_000A);
        chk_busy("preload busy x10", 1, 1'b1);

        // Reset dominates writes and reservations in the same cycle.
        rst_n = 1'b0;
        set_wr(0, 5'd1, 32'h5555_5555, 1'b0);
        reserve(5'd2);
        step();
        rst_n = 1'b1;
        idle();
        for (int a = 0; a < 32; a++) begin
            set_rd(0, 5'(a));
            chk_rd($sformatf("rst data x%0d", a), 0, 32'h0);
            chk_busy($sformatf("rst busy x%0d", a), 0, 1'b0);
        end

        // Same-cycle bypass, then stored value.
        set_wr(0, 5'd5, 32'hDEAD_BEEF, 1'b0);
        set_rd(0, 5'd6);
        set_rd(1, 5'd5);
        chk_rd("bypass x5", 1, 32'hDEAD_BEEF);
        chk_rd("no bypass x6", 0, 32'h0);
        step();
        idle();
        chk_rd("stored x5", 1, 32'hDEAD_BEEF);

        // Write conflict: highest port wins for bypass and storage.
        set_wr(0, 5'd7, 32'h0000_1111, 1'b0);
        set_wr(1, 5'd7, 32'h0000_2222, 1'b0);
        set_rd(0, 5'd7);
        chk_rd("conflict bypass x7", 0, 32'h0000_2222);
        step();
        idle();
        chk_rd("conflict stored x7", 0, 32'h0000_2222);

        // Reservation visible next cycle; retiring write masks and clears.
        set_rd(0, 5'd3);
        reserve(5'd3);
        chk_busy("rsv x3 cycle N", 0, 1'b0);
        step();
        idle();
        chk_busy("rsv x3 cycle N+1", 0, 1'b1);
        step();
        chk_busy("rsv x3 cycle N+2", 0, 1'b1);
        step();
        set_wr(1, 5'd3, 32'h0000_0033, 1'b1);
        chk_busy("retire x3 masked", 0, 1'b0);
        chk_rd("retire x3 bypass", 0, 32'h0000_0033);
        step();
        idle();
        chk_busy("retire x3 after", 0, 1'b0);
        chk_rd("retire x3 data", 0, 32'h0000_0033);

        // A write without wr_clr leaves the reservation in place.
        set_rd(1, 5'd11);
        reserve(5'd11);
        step();
        idle();
        set_wr(0, 5'd11, 32'h0000_00BB, 1'b0);
        chk_busy("noclr x11 same", 1, 1'b1);
        step();
        idle();
        chk_busy("noclr x11 after", 1, 1'b1);
        chk_rd("noclr x11 data", 1, 32'h0000_00BB);

        // Set and clear on the same register: set wins.
        set_rd(0, 5'd9);
        reserve(5'd9);
        step();
        idle();
        chk_busy("x9 pending", 0, 1'b1);
        reserve(5'd9);
        set_wr(0, 5'd9, 32'h0000_0099, 1'b1);
        chk_busy("x9 set+clr masked", 0, 1'b0);
        step();
        idle();
        chk_busy("x9 set wins", 0, 1'b1);
        chk_rd("x9 data", 0, 32'h0000_0099);

        // Flush clears everything and overrides a same-cycle reservation.
        reserve(5'd4);
        step();
        reserve(5'd6);
        step();
        idle();
        set_rd(0, 5'd4);
        set_rd(1, 5'd6);
        chk_busy("x4 reserved", 0, 1'b1);
        chk_busy("x6 reserved", 1, 1'b1);
        flush = 1'b1;
        reserve(5'd8);
        set_wr(1, 5'd12, 32'h0000_000C, 1'b0);
        step();
        idle();
        chk_busy("flush x4", 0, 1'b0);
        chk_busy("flush x6", 1, 1'b0);
        set_rd(0, 5'd8);
        set_rd(1, 5'd9);
        chk_busy("flush x8", 0, 1'b0);
        chk_busy("flush x9", 1, 1'b0);
        set_rd(1, 5'd12);
        chk_rd("flush write x12", 1, 32'h0000_000C);

        // Register 0: writes dropped, reads 0 even when bypassing, never busy.
        set_rd(0, 5'd0);
        set_wr(1, 5'd0, 32'hFFFF_FFFF, 1'b0);
        chk_rd("x0 bypass", 0, 32'h0);
        step();
        idle();
        chk_rd("x0 stored", 0, 32'h0);
        reserve(5'd0);
        step();
        idle();
        chk_busy("x0 rsv", 0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_regfile_sb
